// File: rtl/debug_events_pkg.sv
// Shared types and register-map constants for the debug input event block.
package debug_events_pkg;

  // One queued event: timestamp, changed-bit mask and the new input word.
  typedef struct packed {
    logic [15:0] ts;
    logic [7:0]  chg;
    logic [7:0]  value;
  } event_t;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_EVENT   = 2'd1,
    REG_CURRENT = 2'd2,
    REG_CONTROL = 2'd3
  } reg_addr_e;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_OVERFLOW  = 8;
  localparam int STAT_EMPTY     = 9;
  localparam int STAT_FULL      = 10;

  localparam int CTRL_MASK_LSB  = 0;
  localparam int CTRL_IRQ_EN    = 8;
  localparam int CTRL_FLUSH     = 9;
  localparam int CTRL_CLR_OVF   = 10;

  function automatic logic [31:0] make_status(input logic [5:0] count,
                                              input logic       overflow,
                                              input logic       empty,
                                              input logic       full);
    logic [31:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: 6] = count;
    s[STAT_OVERFLOW]       = overflow;
    s[STAT_EMPTY]          = empty;
    s[STAT_FULL]           = full;
    return s;
  endfunction

endpackage

// File: rtl/debug_input_events_if.sv
// Wishbone classic target bus between the CPU and the event queue.
// Handshake: a request is cyc & stb while ack is low at a rising edge; the
// target answers with ack high for exactly one cycle and data valid with it.
interface debug_input_events_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    input  wb_dat_r, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    output wb_dat_r, wb_ack
  );
endinterface

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO with occupancy count; a push into a full
// FIFO is accepted when a pop happens at the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign count_o = count;
  assign rdata_o = mem[rd_ptr];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/debug_input_events.sv
// Timestamps per-bit changes of the debounced input word, queues them and
// exposes the queue as a Wishbone classic target with a level interrupt.
module debug_input_events
  import debug_events_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         TS_DIV     = 100_000,
  parameter int         IRQ_THRESH = 1,
  parameter logic [7:0] ENABLE_RST = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            inputs_i,
  debug_input_events_if.slave   wb,
  output logic                  irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

  logic [PW-1:0]  prescaler;
  logic           ts_tick;
  logic [15:0]    timestamp;

  logic [7:0]     prev_q;
  logic [7:0]     mask;
  logic           irq_en;
  logic           overflow;

  logic [7:0]     chg;
  logic           push;
  event_t         new_event;

  logic           req;
  reg_addr_e      adr;
  logic           rd_event;
  logic           wr_ctrl;
  logic           flush;
  logic           clr_ovf;
  logic           drop;
  logic [31:0]    rd_data;

  event_t         head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;

  logic           unused_bits;
  assign unused_bits = ^{wb.wb_dat_w[31:11], wb.wb_sel[3:2]};

  // Timestamp base
  assign ts_tick = (prescaler == PW'(TS_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prescaler <= '0;
      timestamp <= '0;
    end else if (ts_tick) begin
      prescaler <= '0;
      timestamp <= timestamp + 16'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Change detection
  assign chg  = (inputs_i ^ prev_q) & mask;
  assign push = |chg;

  always_comb begin
    new_event       = '0;
    new_event.ts    = timestamp;
    new_event.chg   = chg;
    new_event.value = inputs_i;
  end

  // Bus decode; side effects happen only on the request edge.
  assign adr      = reg_addr_e'(wb.wb_adr);
  assign req      = wb.wb_cyc & wb.wb_stb & ~wb.wb_ack;
  assign rd_event = req & ~wb.wb_we & (adr == REG_EVENT);
  assign wr_ctrl  = req &  wb.wb_we & (adr == REG_CONTROL);
  assign flush    = wr_ctrl & wb.wb_sel[1] & wb.wb_dat_w[CTRL_FLUSH];
  assign clr_ovf  = wr_ctrl & wb.wb_sel[1] & wb.wb_dat_w[CTRL_CLR_OVF];

  // A full FIFO still accepts when the same edge pops; a flush discards.
  assign drop = push & fifo_full & ~rd_event & ~flush;

  sync_fifo #(
    .WIDTH ($bits(event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (rd_event),
    .wdata_i (new_event),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rd_data = '0;
    case (adr)
      REG_STATUS:  rd_data = make_status(6'(fifo_count), overflow, fifo_empty, fifo_full);
      REG_EVENT:   rd_data = fifo_empty ? 32'd0 : 32'(head);
      REG_CURRENT: rd_data = {24'd0, prev_q};
      REG_CONTROL: rd_data = {23'd0, irq_en, mask};
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q   <= '0;
      mask     <= ENABLE_RST;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev_q <= inputs_i;
      if (clr_ovf)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      if (wr_ctrl && wb.wb_sel[0]) mask   <= wb.wb_dat_w[CTRL_MASK_LSB +: 8];
      if (wr_ctrl && wb.wb_sel[1]) irq_en <= wb.wb_dat_w[CTRL_IRQ_EN];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb.wb_ack   <= 1'b0;
      wb.wb_dat_r <= '0;
      irq_o       <= 1'b0;
    end else begin
      wb.wb_ack <= req;
      if (req) wb.wb_dat_r <= wb.wb_we ? 32'd0 : rd_data;
      irq_o <= irq_en & (fifo_count >= CW'(IRQ_THRESH));
    end
  end

endmodule
